// File: rtl/sa_shift_unit_if.sv
// Handshake and operand bus for sa_shift_unit: start/busy/done plus the amount sources.
// The master drives the request and operands. The slave returns status and result.
interface sa_shift_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [1:0]       sa_sel;
   logic [15:0]      instr;
   logic [WIDTH-1:0] reg_b;
   logic [WIDTH-1:0] mdr;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             illegal;

   modport master (
      output start, op, sa_sel, instr, reg_b, mdr, data_in,
      input  busy, done, result, illegal
   );

   modport slave (
      input  start, op, sa_sel, instr, reg_b, mdr, data_in,
      output busy, done, result, illegal
   );
endinterface

// File: rtl/sa_shift_unit.sv
// Multi-cycle shift/rotate unit, one bit per cycle; done arrives n+1 edges after the start edge.
// start is sampled only in IDLE and is silently dropped while busy.
module sa_shift_unit #(
   parameter int WIDTH    = 32,
   parameter int SA_W     = $clog2(WIDTH),
   parameter int CONST_SA = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   sa_shift_unit_if.slave bus
);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [SA_W-1:0]  cnt, cnt_nxt;
   logic [2:0]       op_r, op_nxt;
   logic             ill, ill_nxt;
   logic [SA_W-1:0]  sa_instr;
   logic [SA_W-1:0]  sa_amt;
   logic [4:0]       shamt_f;

   assign shamt_f = bus.instr[10:6];

   // The 5-bit shamt field is fitted to the counter width.
   if (SA_W > 5) begin : g_instr_zext
      assign sa_instr = {{(SA_W-5){1'b0}}, shamt_f};
   end else if (SA_W == 5) begin : g_instr_same
      assign sa_instr = shamt_f;
   end else begin : g_instr_trunc
      assign sa_instr = shamt_f[SA_W-1:0];
   end

   always_comb begin
      sa_amt = sa_instr;
      case (bus.sa_sel)
         2'b00:   sa_amt = sa_instr;
         2'b01:   sa_amt = bus.reg_b[SA_W-1:0];
         2'b10:   sa_amt = SA_W'(CONST_SA);
         default: sa_amt = bus.mdr[SA_W-1:0];
      endcase
   end

   function automatic logic [WIDTH-1:0] step1(input logic [2:0] o, input logic [WIDTH-1:0] a);
      logic [WIDTH-1:0] r;
      r = a;
      case (o)
         OP_SLL:  r = {a[WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, a[WIDTH-1:1]};
         OP_SRA:  r = {a[WIDTH-1], a[WIDTH-1:1]};
         OP_ROL:  r = {a[WIDTH-2:0], a[WIDTH-1]};
         OP_ROR:  r = {a[0], a[WIDTH-1:1]};
         default: r = a;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         op_r  <= OP_SLL;
         ill   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         op_r  <= op_nxt;
         ill   <= ill_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      op_nxt    = op_r;
      ill_nxt   = ill;
      case (state)
         IDLE: begin
            if (bus.start) begin
               acc_nxt   = bus.data_in;
               op_nxt    = bus.op;
               ill_nxt   = (bus.op > OP_ROR);
               // Illegal ops finish as a zero-length shift.
               cnt_nxt   = (bus.op > OP_ROR) ? '0 : sa_amt;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == '0) begin
               state_nxt = DONE;
            end else begin
               acc_nxt = step1(op_r, acc);
               cnt_nxt = cnt - SA_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);
   assign bus.result  = acc;
   assign bus.illegal = ill;

endmodule

// File: tb/tb_sa_shift_unit.sv
// Self-checking bench for sa_shift_unit: directed cases plus randomized ops against a reference model.
module tb_sa_shift_unit;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   sa_shift_unit_if #(.WIDTH(32)) bus ();

   sa_shift_unit #(.WIDTH(32), .SA_W(5), .CONST_SA(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: amount selection and whole-word shift/rotate by n at once.
   function automatic int model_amt(input logic [1:0] sel, input logic [15:0] ins,
                                    input logic [31:0] rb, input logic [31:0] md);
      case (sel)
         2'b00:   return int'(ins[10:6]);
         2'b01:   return int'(rb % 32);
         2'b10:   return 16;
         default: return int'(md % 32);
      endcase
   endfunction

   function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] d, input int n);
      logic [63:0] dd;
      dd = {d, d};
      case (o)
         3'd0: return d << n;
         3'd1: return d >> n;
         3'd2: return 32'($signed(d) >>> n);
         3'd3: begin dd = dd << n; return dd[63:32]; end
         3'd4: begin dd = dd >> n; return dd[31:0]; end
         default: return d;
      endcase
   endfunction

   // Presents one request, scrambles operands after capture, waits for done (bounded).
   task automatic run_op(input logic [2:0] o, input logic [1:0] sel, input logic [15:0] ins,
                         input logic [31:0] rb, input logic [31:0] md, input logic [31:0] d,
                         output int lat, output logic [31:0] res, output logic ill);
      @(negedge clk);
      bus.op = o; bus.sa_sel = sel; bus.instr = ins;
      bus.reg_b = rb; bus.mdr = md; bus.data_in = d;
      bus.start = 1'b1;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         bus.start   = 1'b0;
         bus.data_in = $urandom;
         bus.reg_b   = $urandom;
         bus.mdr     = $urandom;
         bus.instr   = 16'($urandom);
         @(negedge clk);
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      res = bus.result;
      ill = bus.illegal;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.op = '0; bus.sa_sel = '0; bus.instr = '0;
      bus.reg_b = '0; bus.mdr = '0; bus.data_in = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0 || bus.illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b result=%h illegal=%b, required 0 0 00000000 0",
                  bus.busy, bus.done, bus.result, bus.illegal);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_sll_instr();
      int lat; logic [31:0] res; logic ill;
      run_op(3'd0, 2'b00, 16'h0100, 32'h0, 32'h0, 32'h0000_0001, lat, res, ill);
      checks++;
      if (lat !== 6 || res !== 32'h0000_0010 || ill !== 1'b0) begin
         errors++;
         $display("FAIL sll_instr: lat=%0d result=%h illegal=%b, required 6 00000010 0", lat, res, ill);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'h0000_0010) begin
         errors++;
         $display("FAIL sll_hold: done=%b busy=%b result=%h, required 0 0 00000010",
                  bus.done, bus.busy, bus.result);
      end
   endtask

   task automatic test_const_sra_srl();
      int lat; logic [31:0] res; logic ill;
      run_op(3'd2, 2'b10, 16'h0, 32'h0, 32'h0, 32'h8000_0000, lat, res, ill);
      checks++;
      if (lat !== 18 || res !== 32'hFFFF_8000 || ill !== 1'b0) begin
         errors++;
         $display("FAIL sra_const: lat=%0d result=%h illegal=%b, required 18 ffff8000 0", lat, res, ill);
      end
      run_op(3'd1, 2'b10, 16'h0, 32'h0, 32'h0, 32'h8000_0000, lat, res, ill);
      checks++;
      if (lat !== 18 || res !== 32'h0000_8000) begin
         errors++;
         $display("FAIL srl_const: lat=%0d result=%h, required 18 00008000", lat, res);
      end
   endtask

   task automatic test_rotate();
      int lat; logic [31:0] res; logic ill;
      run_op(3'd4, 2'b01, 16'h0, 32'h0000_0025, 32'h0, 32'h0000_001F, lat, res, ill);
      checks++;
      if (lat !== 7 || res !== 32'hF800_0000) begin
         errors++;
         $display("FAIL ror_regb: lat=%0d result=%h, required 7 f8000000", lat, res);
      end
      run_op(3'd3, 2'b01, 16'h0, 32'h0000_001F, 32'h0, 32'h0000_0001, lat, res, ill);
      checks++;
      if (lat !== 33 || res !== 32'h8000_0000) begin
         errors++;
         $display("FAIL rol_max: lat=%0d result=%h, required 33 80000000", lat, res);
      end
   endtask

   task automatic test_mdr_zero();
      int lat; logic [31:0] res; logic ill;
      run_op(3'd0, 2'b11, 16'h0, 32'h0, 32'hFFFF_FFE0, 32'hDEAD_BEEF, lat, res, ill);
      checks++;
      if (lat !== 2 || res !== 32'hDEAD_BEEF || ill !== 1'b0) begin
         errors++;
         $display("FAIL mdr_zero: lat=%0d result=%h illegal=%b, required 2 deadbeef 0", lat, res, ill);
      end
   endtask

   task automatic test_ignore_and_reset();
      int lat; logic [31:0] res; logic ill;
      bit seen;
      @(negedge clk);
      bus.op = 3'd0; bus.sa_sel = 2'b01; bus.reg_b = 32'd8; bus.data_in = 32'h0000_00FF;
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: busy=%b, required 1", bus.busy);
      end
      repeat (2) @(negedge clk);
      bus.op = 3'd4; bus.reg_b = 32'd3; bus.data_in = 32'hAAAA_5555; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      for (int k = 0; k < 100 && !bus.done; k++) @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.result !== 32'h0000_FF00) begin
         errors++;
         $display("FAIL ignore_start: done=%b result=%h, required 1 0000ff00", bus.done, bus.result);
      end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL no_queued_op: extra_done=%b busy=%b, required 0 0", seen, bus.busy);
      end
      // Second op aborted by reset partway through its shift.
      bus.op = 3'd1; bus.sa_sel = 2'b10; bus.data_in = 32'h1234_5678; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.result !== 32'h0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: busy=%b result=%h done=%b, required 0 00000000 0",
                  bus.busy, bus.result, bus.done);
      end
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      reset_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: done_seen=%b, required 0", seen);
      end
      run_op(3'd1, 2'b11, 16'h0, 32'h0, 32'h0000_0004, 32'h0000_00F0, lat, res, ill);
      checks++;
      if (lat !== 6 || res !== 32'h0000_000F) begin
         errors++;
         $display("FAIL post_reset_op: lat=%0d result=%h, required 6 0000000f", lat, res);
      end
   endtask

   task automatic test_illegal();
      int lat; logic [31:0] res; logic ill;
      run_op(3'd7, 2'b01, 16'h0, 32'd20, 32'h0, 32'h1234_5678, lat, res, ill);
      checks++;
      if (lat !== 2 || res !== 32'h1234_5678 || ill !== 1'b1) begin
         errors++;
         $display("FAIL illegal_op: lat=%0d result=%h illegal=%b, required 2 12345678 1", lat, res, ill);
      end
      @(negedge clk);
      checks++;
      if (bus.illegal !== 1'b1) begin
         errors++;
         $display("FAIL illegal_hold: illegal=%b, required 1", bus.illegal);
      end
      bus.op = 3'd0; bus.sa_sel = 2'b11; bus.mdr = 32'd3; bus.data_in = 32'h1; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      checks++;
      if (bus.illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clear: illegal=%b, required 0", bus.illegal);
      end
      for (int k = 0; k < 100 && !bus.done; k++) @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.result !== 32'h0000_0008) begin
         errors++;
         $display("FAIL after_illegal: done=%b result=%h, required 1 00000008", bus.done, bus.result);
      end
   endtask

   task automatic test_random_back_to_back();
      int lat, n;
      logic [31:0] res, rb, md, d, exp_res;
      logic [15:0] ins;
      logic [2:0]  o;
      logic [1:0]  sel;
      logic        ill, exp_ill;
      for (int i = 0; i < 40; i++) begin
         o   = 3'($urandom_range(0, 7));
         sel = 2'($urandom_range(0, 3));
         ins = 16'($urandom);
         rb  = $urandom;
         md  = $urandom;
         d   = $urandom;
         exp_ill = (o > 3'd4);
         n       = exp_ill ? 0 : model_amt(sel, ins, rb, md);
         exp_res = model_res(o, d, n);
         run_op(o, sel, ins, rb, md, d, lat, res, ill);
         checks++;
         if (lat !== n + 2 || res !== exp_res || ill !== exp_ill) begin
            errors++;
            $display("FAIL random[%0d] op=%0d sel=%0d d=%h: lat=%0d result=%h illegal=%b, required %0d %h %b",
                     i, o, sel, d, lat, res, ill, n + 2, exp_res, exp_ill);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sll_instr();
      test_const_sra_srl();
      test_rotate();
      test_mdr_zero();
      test_ignore_and_reset();
      test_illegal();
      test_random_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sa_shift_unit.md
# sa_shift_unit

Parametrised, multi-cycle shift unit for the multicycle datapath. It selects the shift amount from one of four sources: the instruction shamt field, register B, a constant, or MDR. It then shifts or rotates a captured operand one bit per cycle under a start/busy/done handshake. The control FSM starts it in the execute step and waits for `done` before writeback.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be ≥ 2.
- `SA_W`, $clog2(WIDTH), shift-amount width.
- `CONST_SA`, 16, constant amount for selector 2'b10; must be < WIDTH.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation:
  - 000 SLL
  - 001 SRL
  - 010 SRA
  - 011 ROL
  - 100 ROR
  - 101–111 illegal
- `sa_sel`  in  2  amount source:
  - 00 `instr[10:6]`
  - 01 `reg_b[SA_W-1:0]`
  - 10 `CONST_SA`
  - 11 `mdr[SA_W-1:0]`
- `instr`  in  16  instruction low half.
- `reg_b`  in  WIDTH  register B.
- `mdr`  in  WIDTH  memory data register.
- `data_in`  in  WIDTH  operand to shift.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  shifted value, registered.
- `illegal`  out  1  registered; set when the last accepted `op` was 101–111.

## Operation
- Amount select is combinational and only used at capture.
  - The `instr[10:6]` field is zero-extended to SA_W if SA_W > 5, or truncated to its low SA_W bits if SA_W < 5.
  - Register sources use their low SA_W bits only; upper bits are ignored.
- FSM states are IDLE, SHIFT, DONE.
- IDLE with `start`=1, on the edge:
  - Capture: acc←`data_in`, cnt←selected amount, op_r←`op`, `illegal`←(op≥101).
  - Go to SHIFT.
  - If `op` is illegal, force cnt←0.
- SHIFT:
  - If cnt = 0, go to DONE.
  - Otherwise apply one single-bit step to acc and do cnt←cnt−1.
- Single-bit steps:
  - SLL: {acc[W-2:0],0}
  - SRL: {0,acc[W-1:1]}
  - SRA: {acc[W-1],acc[W-1:1]}
  - ROL: {acc[W-2:0],acc[W-1]}
  - ROR: {acc[0],acc[W-1:1]}
- DONE: `done`=1 for this cycle only, then go to IDLE unconditionally.
- `result` = acc. It is valid while `done`=1 and is held until the next accepted `start` overwrites it.
- `start` while `busy`=1 (SHIFT or DONE) is ignored. It is neither queued nor an error.
- An illegal op completes as a zero-length shift: `result`=`data_in` and `illegal`=1 alongside `done`. `illegal` holds until the next accepted `start`.
- Amount 0 is legal: `result`=`data_in`, `illegal`=0.

## Timing
- Reset (async assert, synchronous release to first edge) sets: state=IDLE, acc=0, cnt=0, `result`=0, `busy`=0, `done`=0, `illegal`=0.
- Start edge E0 (IDLE, `start`=1):
  - `busy` rises after E0.
  - Edges E1…E_n perform n shift steps (n = amount).
  - Edge E_{n+1} enters DONE.
  - `done` is high in the cycle after E_{n+1}.
  - Edge E_{n+2} returns to IDLE; `busy` and `done` fall.
- Total latency from the start edge to the `done` cycle is n+1 edges, so `done` appears n+2 cycles after the cycle in which `start` is presented.
- Back-to-back operation: `start` may be asserted in the cycle after `done`, when the FSM is back in IDLE. Maximum throughput is one op per n+3 cycles.
- Inputs other than `start`, `op`, `sa_sel`, and the selected source are don't-care outside the capture edge. Changing `data_in`, `reg_b` or `mdr` mid-shift has no effect.
- Reset asserted mid-operation aborts immediately to reset values. No `done` is produced, and the first post-reset `start` behaves normally.
- Maximum amount is 2^SA_W−1, i.e. 31 steps for WIDTH=32. There is no wrap and no early exit.

## Test plan
- SLL, `sa_sel`=00, `instr`=16'h0100 (shamt=4), `data_in`=32'h0000_0001 -> `done` 6 cycles after start, `result`=32'h0000_0010, `illegal`=0.
- SRA, `sa_sel`=10 (16), `data_in`=32'h8000_0000 -> `result`=32'hFFFF_8000 with `done` after 18 cycles. SRL with the same stimulus -> 32'h0000_8000.
- ROR, `sa_sel`=01, `reg_b`=32'h0000_0025 (low bits 5), `data_in`=32'h0000_001F -> `result`=32'hF800_0000. ROL by 31 of 32'h0000_0001 -> 32'h8000_0000.
- `sa_sel`=11, `mdr`=32'hFFFF_FFE0 (low bits 0), `data_in`=32'hDEAD_BEEF -> `done` 2 cycles after start, `result`=32'hDEAD_BEEF.
- Start SLL by 8. Pulse `start` with a different op during SHIFT -> ignored; the first op's result is unchanged. Assert `reset_n`=0 mid-shift of a second op -> `busy`=0, `result`=0 immediately, no `done`.
- `op`=3'b111, `data_in`=32'h1234_5678, amount 20 -> `done` 2 cycles after start, `result`=32'h1234_5678, `illegal`=1. The next legal start clears `illegal` on its capture edge.
